// File: rtl/game_board_pkg.sv
// Shared cell, status and FSM encodings for the m,n,k board engine.
package game_board_pkg;

  localparam logic [1:0] CELL_BLANK = 2'd0;
  localparam logic [1:0] CELL_X     = 2'd1;
  localparam logic [1:0] CELL_O     = 2'd2;
  localparam logic [1:0] CELL_RSVD  = 2'd3;

  localparam logic [1:0] ST_PLAY = 2'd0;
  localparam logic [1:0] ST_XWIN = 2'd1;
  localparam logic [1:0] ST_OWIN = 2'd2;
  localparam logic [1:0] ST_DRAW = 2'd3;

  typedef enum logic [1:0] {
    S_PLAY  = 2'd0,
    S_CHECK = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Width of a row/column index; a single row or column still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cell_idx(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/game_board_line_run.sv
// Combinational run detector: counts same-player cells through the last move along one direction.
module line_run_m
  import game_board_pkg::*;
#(
  parameter int ROWS    = 3,
  parameter int COLS    = 3,
  parameter int WIN_LEN = 3,
  localparam int ROW_W  = idx_w(ROWS),
  localparam int COL_W  = idx_w(COLS),
  localparam int CELLS  = ROWS * COLS
) (
  input  logic [2*CELLS-1:0] board_i,
  input  logic [ROW_W-1:0]   row_i,
  input  logic [COL_W-1:0]   col_i,
  input  logic [1:0]         dir_i,
  input  logic [1:0]         player_i,
  output logic               win_o
);

  function automatic logic [1:0] cell_of(input logic [2*CELLS-1:0] b, input int idx);
    cell_of = CELL_BLANK;
    for (int i = 0; i < CELLS; i++) begin
      if (i == idx) cell_of = b[2*i +: 2];
    end
  endfunction

  int  dr;
  int  dc;
  int  run;
  int  rr;
  int  cc;
  logic open;

  always_comb begin
    dr   = 0;
    dc   = 1;
    run  = 1;
    rr   = 0;
    cc   = 0;
    open = 1'b0;
    case (dir_i)
      2'd1:    begin dr = 1; dc = 0;  end
      2'd2:    begin dr = 1; dc = 1;  end
      2'd3:    begin dr = 1; dc = -1; end
      default: begin dr = 0; dc = 1;  end
    endcase
    // Side 0 walks forward along (dr,dc), side 1 walks backward; each side stops at
    // the first foreign cell or board edge and never looks past WIN_LEN-1 cells.
    for (int s = 0; s < 2; s++) begin
      open = 1'b1;
      for (int k = 1; k < WIN_LEN; k++) begin
        rr = int'(row_i) + ((s == 0) ? k : -k) * dr;
        cc = int'(col_i) + ((s == 0) ? k : -k) * dc;
        if (open) begin
          if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) begin
            open = 1'b0;
          end else if (cell_of(board_i, cell_idx(rr, cc, COLS)) == player_i) begin
            run = run + 1;
          end else begin
            open = 1'b0;
          end
        end
      end
    end
    win_o = (run >= WIN_LEN);
  end

endmodule

// File: rtl/game_board_m.sv
// m,n,k board state engine: move handshake, legality, 4-direction win scan, draw detection.
// Optional single-level undo when GAME_BOARD_UNDO_EN is defined.
//
// state   | meaning
// S_PLAY  | waiting for a move (or undo)
// S_CHECK | scanning the four lines through the last move, one direction per cycle
// S_DONE  | game over (win or draw); board frozen until reset/restart (or undo)
module game_board_m
  import game_board_pkg::*;
#(
  parameter int ROWS    = 3,
  parameter int COLS    = 3,
  parameter int WIN_LEN = 3,
  localparam int ROW_W  = idx_w(ROWS),
  localparam int COL_W  = idx_w(COLS),
  localparam int CELLS  = ROWS * COLS,
  localparam int CNT_W  = $clog2(CELLS + 1)
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               restart_i,
  input  logic               move_valid_i,
  output logic               move_ready_o,
  input  logic [ROW_W-1:0]   move_row_i,
  input  logic [COL_W-1:0]   move_col_i,
  output logic               move_err_o,
  output logic               move_done_o,
  output logic [1:0]         turn_o,
  output logic [1:0]         status_o,
  output logic [CNT_W-1:0]   move_count_o,
  output logic [2*CELLS-1:0] board_o
`ifdef GAME_BOARD_UNDO_EN
  ,
  input  logic               undo_i,
  output logic               undo_avail_o
`endif
);

  function automatic logic [1:0] cell_of(input logic [2*CELLS-1:0] b, input int idx);
    cell_of = CELL_BLANK;
    for (int i = 0; i < CELLS; i++) begin
      if (i == idx) cell_of = b[2*i +: 2];
    end
  endfunction

  state_e             state_q, state_d;
  logic [2*CELLS-1:0] board_q, board_d;
  logic [1:0]         turn_q, turn_d;
  logic [1:0]         status_q, status_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ROW_W-1:0]   last_row_q, last_row_d;
  logic [COL_W-1:0]   last_col_q, last_col_d;
  logic [1:0]         dir_q, dir_d;
  logic               win_q, win_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
`ifdef GAME_BOARD_UNDO_EN
  logic               undo_avail_q, undo_avail_d;
  logic               undo_fire;
  int                 last_idx;
`endif

  int   acc_idx;
  logic in_range;
  logic legal;
  logic line_win;
  logic win_acc;

  assign acc_idx  = cell_idx(int'(move_row_i), int'(move_col_i), COLS);
  assign in_range = (int'(move_row_i) < ROWS) && (int'(move_col_i) < COLS);
  assign legal    = in_range && (cell_of(board_q, acc_idx) == CELL_BLANK);
  assign win_acc  = win_q | line_win;

`ifdef GAME_BOARD_UNDO_EN
  // An undo request blocks the move path in the same cycle, valid or not.
  assign move_ready_o = (state_q == S_PLAY) && !undo_i;
  assign undo_fire    = undo_i && undo_avail_q && (state_q != S_CHECK);
  assign last_idx     = cell_idx(int'(last_row_q), int'(last_col_q), COLS);
  assign undo_avail_o = undo_avail_q;
`else
  assign move_ready_o = (state_q == S_PLAY);
`endif

  line_run_m #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .WIN_LEN (WIN_LEN)
  ) u_line_run (
    .board_i  (board_q),
    .row_i    (last_row_q),
    .col_i    (last_col_q),
    .dir_i    (dir_q),
    .player_i (turn_q),
    .win_o    (line_win)
  );

  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    turn_d     = turn_q;
    status_d   = status_q;
    count_d    = count_q;
    last_row_d = last_row_q;
    last_col_d = last_col_q;
    dir_d      = dir_q;
    win_d      = win_q;
    err_d      = 1'b0;
    done_d     = 1'b0;
`ifdef GAME_BOARD_UNDO_EN
    undo_avail_d = undo_avail_q;
    if (undo_fire) begin
      for (int i = 0; i < CELLS; i++) begin
        if (i == last_idx) board_d[2*i +: 2] = CELL_BLANK;
      end
      turn_d       = cell_of(board_q, last_idx);
      count_d      = count_q - CNT_W'(1);
      status_d     = ST_PLAY;
      state_d      = S_PLAY;
      dir_d        = 2'd0;
      win_d        = 1'b0;
      undo_avail_d = 1'b0;
    end else begin
`endif
    case (state_q)
      S_PLAY: begin
        if (move_valid_i && move_ready_o) begin
          if (legal) begin
            for (int i = 0; i < CELLS; i++) begin
              if (i == acc_idx) board_d[2*i +: 2] = turn_q;
            end
            count_d    = count_q + CNT_W'(1);
            last_row_d = move_row_i;
            last_col_d = move_col_i;
            dir_d      = 2'd0;
            win_d      = 1'b0;
            state_d    = S_CHECK;
`ifdef GAME_BOARD_UNDO_EN
            undo_avail_d = 1'b1;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CHECK: begin
        dir_d = dir_q + 2'd1;
        win_d = win_acc;
        // All four directions are always scanned before deciding; a win on the
        // last free cell takes precedence over the draw.
        if (dir_q == 2'd3) begin
          done_d = 1'b1;
          win_d  = 1'b0;
          if (win_acc) begin
            status_d = (turn_q == CELL_X) ? ST_XWIN : ST_OWIN;
            state_d  = S_DONE;
          end else if (count_q == CNT_W'(CELLS)) begin
            status_d = ST_DRAW;
            state_d  = S_DONE;
          end else begin
            turn_d  = (turn_q == CELL_X) ? CELL_O : CELL_X;
            state_d = S_PLAY;
          end
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_PLAY;
      end
    endcase
`ifdef GAME_BOARD_UNDO_EN
    end
`endif
  end

  always_ff @(posedge clock_i) begin
    if (reset_i || restart_i) begin
      state_q    <= S_PLAY;
      board_q    <= '0;
      turn_q     <= CELL_X;
      status_q   <= ST_PLAY;
      count_q    <= '0;
      last_row_q <= '0;
      last_col_q <= '0;
      dir_q      <= 2'd0;
      win_q      <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
`ifdef GAME_BOARD_UNDO_EN
      undo_avail_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      turn_q     <= turn_d;
      status_q   <= status_d;
      count_q    <= count_d;
      last_row_q <= last_row_d;
      last_col_q <= last_col_d;
      dir_q      <= dir_d;
      win_q      <= win_d;
      err_q      <= err_d;
      done_q     <= done_d;
`ifdef GAME_BOARD_UNDO_EN
      undo_avail_q <= undo_avail_d;
`endif
    end
  end

  assign move_err_o   = err_q;
  assign move_done_o  = done_q;
  assign turn_o       = turn_q;
  assign status_o     = status_q;
  assign move_count_o = count_q;
  assign board_o      = board_q;

endmodule
